// File: rtl/axi4_lite_write_slave.sv
// axi4_lite_write_slave: AXI4-Lite write responder that pairs AW/W beats and commits them to a byte-strobed word store
// Each channel has a one-entry holding slot. A full pair commits once the single B response register can accept it.
module axi4_lite_write_slave #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = '0,
  parameter int MEM_DEPTH = 16,
  parameter bit DEFAULT_READY = 1'b0,
  parameter bit PRIV_ONLY = 1'b0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDRESS_WIDTH-1:0]     awaddr,
  input  logic [2:0]                   awprot,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_index,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] SPAN = (ADDRESS_WIDTH + 1)'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {B_IDLE, B_RESP} b_state_t;

  b_state_t                 r_b_state;
  b_state_t                 w_b_next;
  logic                     r_aw_full;
  logic [ADDRESS_WIDTH-1:0] r_aw_addr;
  logic                     r_aw_priv;
  logic                     r_w_full;
  logic [DATA_WIDTH-1:0]    r_w_data;
  logic [STRB_WIDTH-1:0]    r_w_strb;
  logic                     r_awready;
  logic                     r_wready;
  logic [1:0]               r_bresp;
  logic [DATA_WIDTH-1:0]    r_mem [MEM_DEPTH];
  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_commit;
  logic [ADDRESS_WIDTH-1:0] w_off;
  logic                     w_in_range;
  logic [1:0]               w_resp;
  logic [IW-1:0]            w_idx;
  logic                     w_unused;

  // Only the privileged bit of awprot affects the response.
  assign w_unused = ^awprot[2:1];

  assign awready = DEFAULT_READY ? (!r_aw_full && !areset) : r_awready;
  assign wready = DEFAULT_READY ? (!r_w_full && !areset) : r_wready;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs = wvalid && wready;
  assign bvalid = r_b_state == B_RESP;
  assign bresp = r_bresp;
  assign w_commit = r_aw_full && r_w_full && (!bvalid || bready);

  assign w_off = r_aw_addr - MIN_ADDRESS;
  assign w_in_range = (r_aw_addr >= MIN_ADDRESS) && ({1'b0, w_off} < SPAN);
  assign w_idx = w_off[LSB +: IW];
  assign w_resp = !w_in_range ? DECERR :
                  (r_aw_addr[LSB-1:0] != '0) ? SLVERR :
                  (PRIV_ONLY && !r_aw_priv) ? SLVERR : OKAY;
  assign dbg_data = r_mem[dbg_index];

  always_ff @(posedge aclk) begin
    r_b_state <= areset ? B_IDLE : w_b_next;
  end

  always_comb begin
    w_b_next = r_b_state;
    w_b_next = w_commit ? B_RESP : (bvalid && bready) ? B_IDLE : r_b_state;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_aw_priv <= 1'b0;
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_bresp <= OKAY;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Pulsed ready: one cycle after valid is seen against an empty slot.
      r_awready <= awvalid && !r_aw_full && !r_awready;
      r_wready <= wvalid && !r_w_full && !r_wready;
      r_aw_full <= w_aw_hs || (r_aw_full && !w_commit);
      r_w_full <= w_w_hs || (r_w_full && !w_commit);
      if (w_aw_hs) begin
        r_aw_addr <= awaddr;
        r_aw_priv <= awprot[0];
      end
      if (w_w_hs) begin
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end
      if (w_commit) r_bresp <= w_resp;
      if (w_commit && w_resp == OKAY)
        for (int i = 0; i < STRB_WIDTH; i++)
          if (r_w_strb[i]) r_mem[w_idx][8*i +: 8] <= r_w_data[8*i +: 8];
    end
  end
endmodule
